// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory.
// Both sides size their address buses with clogb2() from here so the widths
// cannot drift apart.
//   loader_state_t    : 3-bit loader FSM encoding
//   DEFAULT_HALT_WORD : word that terminates a program load
//   clogb2()          : ceil(log2(value)), minimum 0
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  function automatic int clogb2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Byte-to-word assembler for the instruction loader.
// Bytes shift in from the LSB side so the first byte of a word lands in the
// top byte (big-endian). A down-counter tracks the bytes still missing; the
// strobe that hits terminal count completes the word.
//   i_clock, i_reset : clock, async active-high reset
//   i_clear          : restart assembly (counter reload, shift register zero)
//   i_byte           : incoming byte
//   i_byte_strobe    : i_byte is consumed this cycle
//   o_word           : word including the byte being consumed this cycle
//   o_word_valid     : o_word is complete at this edge (one-cycle pulse)
module byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_strobe,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BCNT-1:0] BCNT_LOAD = NB_BCNT'(NB_BYTES - 1);

  logic [NB_DATA-1:0] shift_q;
  logic [NB_BCNT-1:0] bcnt_q;

  // Shift written as a shift/or so it also holds for an 8-bit word.
  assign o_word       = (shift_q << 8) | NB_DATA'(i_byte);
  assign o_word_valid = i_byte_strobe && (bcnt_q == '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      bcnt_q  <= BCNT_LOAD;
    end else if (i_clear) begin
      shift_q <= '0;
      bcnt_q  <= BCNT_LOAD;
    end else if (i_byte_strobe) begin
      shift_q <= o_word;
      if (bcnt_q == '0) begin
        bcnt_q <= BCNT_LOAD;
      end else begin
        bcnt_q <= bcnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Program loader for the instruction memory. Assembles big-endian words from
// a byte stream, writes them to consecutive word addresses and keeps the CPU
// in reset until the halt word has been stored.
//   i_clock, i_reset    : clock, async active-high reset
//   i_start             : one-cycle request to begin a load (IDLE/DONE/ERROR)
//   i_byte/i_byte_valid : byte stream, handshake with o_byte_ready
//   o_wr_addr/o_wr_data : byte address and word, qualified by o_wr_enable
//   o_cpu_reset         : CPU/fetch held in reset
//   o_cpu_enable        : CPU may run
//   o_done              : halt word stored
//   o_overflow          : memory filled before the halt word
//   o_word_count        : words written in the current load
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for i_start
// ST_RECV  | accepting bytes of the current word
// ST_WRITE | single-cycle write strobe of the assembled word
// ST_DONE  | halt word stored, CPU released
// ST_ERROR | memory full without halt word, CPU kept in reset
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int NB_DATA            = 32,
  parameter int N_ADDR             = 2048,
  parameter int LOG2_N_INSMEM_ADDR = clogb2(N_ADDR),
  parameter logic [NB_DATA-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [7:0]                      i_byte,
  input  logic                            i_byte_valid,
  output logic                            o_byte_ready,
  output logic [LOG2_N_INSMEM_ADDR-1:0]   o_wr_addr,
  output logic [NB_DATA-1:0]              o_wr_data,
  output logic                            o_wr_enable,
  output logic                            o_cpu_reset,
  output logic                            o_cpu_enable,
  output logic                            o_done,
  output logic                            o_overflow,
  output logic [LOG2_N_INSMEM_ADDR-2:0]   o_word_count
);

  localparam int NB_CNT = LOG2_N_INSMEM_ADDR - 1;
  // Number of words that fit in memory; reaching it without a halt is an error.
  localparam logic [NB_CNT-1:0] MAX_WORDS = NB_CNT'(2 ** (LOG2_N_INSMEM_ADDR - 2));

  loader_state_t state_q, state_d;

  logic [NB_CNT-1:0]             word_count_q;
  logic [NB_CNT-1:0]             count_inc;
  logic [LOG2_N_INSMEM_ADDR-1:0] wr_addr_q;
  logic [NB_DATA-1:0]            wr_data_q;
  logic                          load_clear;
  logic                          byte_strobe;
  logic [NB_DATA-1:0]            asm_word;
  logic                          asm_word_valid;

  assign byte_strobe = i_byte_valid && (state_q == ST_RECV);
  assign count_inc   = word_count_q + NB_CNT'(1);

  byte_assembler #(
    .NB_DATA (NB_DATA)
  ) u_byte_assembler (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_clear       (load_clear),
    .i_byte        (i_byte),
    .i_byte_strobe (byte_strobe),
    .o_word        (asm_word),
    .o_word_valid  (asm_word_valid)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d    = ST_RECV;
          load_clear = 1'b1;
        end
      end
      ST_RECV: begin
        if (asm_word_valid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_data_q == HALT_WORD) begin
          state_d = ST_DONE;
        end else if (count_inc == MAX_WORDS) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and data are captured when the word completes, so they are
  // stable for the whole WRITE cycle and hold afterwards.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_count_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      if (load_clear) begin
        word_count_q <= '0;
      end else if (state_q == ST_WRITE) begin
        word_count_q <= count_inc;
      end
      if ((state_q == ST_RECV) && asm_word_valid) begin
        wr_addr_q <= {word_count_q[NB_CNT-2:0], 2'b00};
        wr_data_q <= asm_word;
      end
    end
  end

  assign o_byte_ready = (state_q == ST_RECV);
  assign o_wr_enable  = (state_q == ST_WRITE);
  assign o_cpu_reset  = (state_q != ST_DONE);
  assign o_cpu_enable = (state_q == ST_DONE);
  assign o_done       = (state_q == ST_DONE);
  assign o_overflow   = (state_q == ST_ERROR);
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a 16-word memory (N_ADDR=64).
module tb_instruction_loader;

  localparam int NB_DATA = 32;
  localparam int N_ADDR  = 64;
  localparam int LOG2    = 6;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              i_byte_valid = 1'b0;
  logic              o_byte_ready;
  logic [LOG2-1:0]   o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;
  logic              o_wr_enable;
  logic              o_cpu_reset;
  logic              o_cpu_enable;
  logic              o_done;
  logic              o_overflow;
  logic [LOG2-2:0]   o_word_count;

  instruction_loader #(
    .NB_DATA (NB_DATA),
    .N_ADDR  (N_ADDR)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_wr_enable  (o_wr_enable),
    .o_cpu_reset  (o_cpu_reset),
    .o_cpu_enable (o_cpu_enable),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_accept_cyc = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  logic [31:0]     wr_data_log[$];
  logic [LOG2-1:0] wr_addr_log[$];
  int              wr_cyc_log[$];

  always @(negedge i_clock) begin
    if (o_wr_enable) begin
      wr_data_log.push_back(o_wr_data);
      wr_addr_log.push_back(o_wr_addr);
      wr_cyc_log.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_log();
    wr_data_log.delete();
    wr_addr_log.delete();
    wr_cyc_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!o_byte_ready) check_val("byte_ready_timeout", o_byte_ready, 1);
    tick();
    last_accept_cyc = cyc;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    clear_log();
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [LOG2-1:0] addr, input logic [31:0] data);
    if (wr_data_log.size() > idx) begin
      check_val({tag, "_addr"}, wr_addr_log[idx], addr);
      check_val({tag, "_data"}, wr_data_log[idx], data);
    end else begin
      check_val({tag, "_missing"}, wr_data_log.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n1;
    logic [7:0] gap_bytes[8];
    gap_bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset state
    tick();
    check_val("rst_cpu_reset", o_cpu_reset, 1);
    check_val("rst_outputs", {o_byte_ready, o_wr_enable, o_cpu_enable, o_done, o_overflow}, 0);
    check_val("rst_word_count", o_word_count, 0);
    check_val("rst_wr_addr", o_wr_addr, 0);
    check_val("rst_wr_data", o_wr_data, 0);
    i_reset = 1'b0;
    clear_log();

    // Basic load
    pulse_start();
    check_val("basic_ready", o_byte_ready, 1);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    tick();
    check_val("basic_nwrites", wr_data_log.size(), 2);
    check_write("basic_w0", 0, 6'h00, 32'h2001_0005);
    check_write("basic_w1", 1, 6'h04, 32'hFFFF_FFFF);
    check_val("basic_done", o_done, 1);
    check_val("basic_cpu_enable", o_cpu_enable, 1);
    check_val("basic_cpu_reset", o_cpu_reset, 0);
    check_val("basic_word_count", o_word_count, 2);
    check_val("basic_hold_data", o_wr_data, 32'hFFFF_FFFF);

    // Reload from DONE with ignored start/valid
    clear_log();
    pulse_start();
    check_val("reload_cpu_reset", o_cpu_reset, 1);
    check_val("reload_done_low", {o_done, o_cpu_enable}, 0);
    check_val("reload_count_clr", o_word_count, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    check_val("reload_start_in_recv", o_byte_ready, 1);
    send_byte(8'hCC);
    send_byte(8'hDD);
    i_byte = 8'h11;
    i_byte_valid = 1'b1;
    check_val("reload_write_not_ready", o_byte_ready, 0);
    check_val("reload_write_strobe", o_wr_enable, 1);
    tick();
    i_byte_valid = 1'b0;
    send_word(32'hFFFF_FFFF);
    tick();
    check_val("reload_nwrites", wr_data_log.size(), 2);
    check_write("reload_w0", 0, 6'h00, 32'hAABB_CCDD);
    check_write("reload_w1", 1, 6'h04, 32'hFFFF_FFFF);
    check_val("reload_done", o_done, 1);

    // Gapped stream, valid in IDLE ignored
    do_reset();
    i_byte = 8'h55;
    i_byte_valid = 1'b1;
    tick();
    tick();
    i_byte_valid = 1'b0;
    check_val("idle_no_write", wr_data_log.size(), 0);
    pulse_start();
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(gap_bytes[i]);
      if (i == 3) n1 = last_accept_cyc;
      repeat (3) tick();
    end
    check_val("gap_nwrites", wr_data_log.size(), 2);
    check_write("gap_w0", 0, 6'h00, 32'h2001_0005);
    check_write("gap_w1", 1, 6'h04, 32'hFFFF_FFFF);
    if (wr_cyc_log.size() > 0) check_val("gap_write_latency", wr_cyc_log[0], n1);
    check_val("gap_done", o_done, 1);
    check_val("gap_word_count", o_word_count, 2);

    // Overflow: 16 non-halt words fill the memory
    do_reset();
    pulse_start();
    for (int w = 0; w < 16; w++) send_word({8'h10 + 8'(w), 8'h22, 8'h33, 8'h44});
    tick();
    check_val("ovf_overflow", o_overflow, 1);
    check_val("ovf_cpu_reset", o_cpu_reset, 1);
    check_val("ovf_done_low", {o_done, o_cpu_enable}, 0);
    check_val("ovf_word_count", o_word_count, 16);
    check_write("ovf_first", 0, 6'h00, 32'h1022_3344);
    check_write("ovf_last", 15, 6'h3C, 32'h1F22_3344);
    i_byte = 8'hFF;
    i_byte_valid = 1'b1;
    check_val("ovf_not_ready", o_byte_ready, 0);
    repeat (6) tick();
    i_byte_valid = 1'b0;
    check_val("ovf_nwrites", wr_data_log.size(), 16);
    check_val("ovf_sticky", o_overflow, 1);
    pulse_start();
    check_val("ovf_restart_ready", o_byte_ready, 1);
    check_val("ovf_restart_flag", o_overflow, 0);
    check_val("ovf_restart_count", o_word_count, 0);

    // Mid-word reset
    clear_log();
    send_word(32'h0102_0304);
    send_byte(8'h05);
    send_byte(8'h06);
    check_write("mid_w0", 0, 6'h00, 32'h0102_0304);
    i_reset = 1'b1;
    #1;
    check_val("mid_rst_wr_enable", o_wr_enable, 0);
    check_val("mid_rst_cpu_reset", o_cpu_reset, 1);
    check_val("mid_rst_ready", o_byte_ready, 0);
    check_val("mid_rst_count", o_word_count, 0);
    tick();
    i_reset = 1'b0;
    clear_log();
    pulse_start();
    send_word(32'h0A0B_0C0D);
    tick();
    check_val("mid_nwrites", wr_data_log.size(), 1);
    check_write("mid_reload", 0, 6'h00, 32'h0A0B_0C0D);
    check_val("mid_word_count", o_word_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
